// File: rtl/sync_filter_multi.sv
// Multi-channel input synchronizer with consecutive-sample glitch filter.
// Each channel produces a clean level plus one-cycle rise/fall pulses.
`timescale 1ns/1ps
module sync_filter_multi #(
  parameter int   WIDTH     = 4,
  parameter int   STAGES    = 2,
  parameter int   FILTER    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  generate
    if (WIDTH < 1 || STAGES < 2 || FILTER < 1) begin : g_bad_params
      $fatal(1, "sync_filter_multi: need WIDTH>=1, STAGES>=2, FILTER>=1");
    end
  endgenerate

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic             changed_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [STAGES-1:0] chain_reg;
      logic [CW-1:0]     cnt_reg;
      logic              differ;
      logic              commit;

      // Plain flop chain: bit 0 captures the raw input, the top bit is the synchronized sample.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain_reg <= {STAGES{RESET_VAL}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], d[gi]};
        end
      end

      assign s[gi]  = chain_reg[STAGES-1];
      assign differ = s[gi] ^ q_reg[gi];
      assign commit = differ && (cnt_reg == CNT_LAST);

      // Any sample that agrees with q restarts the count, so short excursions never commit.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (!differ || commit) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign q_next[gi]    = commit ? s[gi] : q_reg[gi];
      assign rise_next[gi] = commit &  s[gi];
      assign fall_next[gi] = commit & ~s[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg       <= {WIDTH{RESET_VAL}};
      rise_reg    <= '0;
      fall_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      changed_reg <= |(rise_next | fall_next);
    end
  end

  assign q       = q_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign changed = changed_reg;

endmodule
